// File: rtl/reset_gen.sv
// Reset request generator: merges power-on, debounced button and software resets
// into a registered pulse of guaranteed minimum width. RESET_GEN_WDT_EN adds a watchdog source.
module reset_gen #(
  parameter int POR_CYCLES      = 16,
  parameter int PULSE_CYCLES    = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WDT_CYCLES      = 32,
  parameter int CNT_W           = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn,
  input  logic       i_sw_req,
`ifdef RESET_GEN_WDT_EN
  input  logic       i_wdt_kick,
`endif
  output logic       o_rst,
  output logic [1:0] o_cause,
  output logic       o_done,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    ST_POR      = 2'd0,
    ST_IDLE     = 2'd1,
    ST_ASSERT   = 2'd2,
    ST_WAIT_BTN = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_BTN = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  localparam int MAX_AB     = (POR_CYCLES > PULSE_CYCLES) ? POR_CYCLES : PULSE_CYCLES;
  localparam int MAX_CD     = (DEBOUNCE_CYCLES > WDT_CYCLES) ? DEBOUNCE_CYCLES : WDT_CYCLES;
  localparam int MAX_CYCLES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;

  if (POR_CYCLES < 1 || PULSE_CYCLES < 1 || MAX_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_params
    $error("reset_gen: PULSE/POR cycles must be >= 1 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] POR_LAST   = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_MAX    = CNT_W'(DEBOUNCE_CYCLES);

  // Button path: two-flop synchroniser, then a saturating run-length counter.
  logic             btn_meta;
  logic             btn_sync;
  logic [CNT_W-1:0] deb_cnt;
  logic             btn_pressed;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      btn_meta <= i_btn;
      btn_sync <= btn_meta;
      if (!btn_sync) begin
        deb_cnt <= '0;
      end else if (deb_cnt != DEB_MAX) begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign btn_pressed = (deb_cnt == DEB_MAX);

  // Requests (debounced button, i_sw_req, watchdog expiry) have no ready: they are
  // sampled only in IDLE and silently dropped in every other state.
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rst_d, done_d;
  logic [1:0]       cause_d;

`ifdef RESET_GEN_WDT_EN
  localparam logic [1:0]       CAUSE_WDT = 2'b11;
  localparam logic [CNT_W-1:0] WDT_LAST  = CNT_W'(WDT_CYCLES - 1);
  logic [CNT_W-1:0] wdt_q, wdt_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_d   = o_rst;
    cause_d = o_cause;
    done_d  = 1'b0;
`ifdef RESET_GEN_WDT_EN
    wdt_d   = '0;
`endif
    unique case (state_q)
      ST_POR: begin
        if (cnt_q == POR_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          rst_d   = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        rst_d = 1'b0;
        if (btn_pressed) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          rst_d   = 1'b1;
          cause_d = CAUSE_BTN;
        end else if (i_sw_req) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          rst_d   = 1'b1;
          cause_d = CAUSE_SW;
`ifdef RESET_GEN_WDT_EN
        end else if (i_wdt_kick) begin
          wdt_d = '0;
        end else if (wdt_q == WDT_LAST) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          rst_d   = 1'b1;
          cause_d = CAUSE_WDT;
        end else begin
          wdt_d = wdt_q + 1'b1;
`endif
        end
      end
      ST_ASSERT: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d = '0;
          if (btn_pressed) begin
            state_d = ST_WAIT_BTN;
          end else begin
            state_d = ST_IDLE;
            rst_d   = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_BTN: begin
        if (!btn_pressed) begin
          state_d = ST_IDLE;
          rst_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_POR;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_POR;
      cnt_q   <= '0;
      o_rst   <= 1'b1;
      o_cause <= CAUSE_POR;
      o_done  <= 1'b0;
`ifdef RESET_GEN_WDT_EN
      wdt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_rst   <= rst_d;
      o_cause <= cause_d;
      o_done  <= done_d;
`ifdef RESET_GEN_WDT_EN
      wdt_q   <= wdt_d;
`endif
    end
  end

  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_reset_gen.sv
// Bench for reset_gen: directed scenarios with literal expectations, then randomized
// stimulus checked every cycle against a countdown-based model of the reset rules.
module tb_reset_gen;

  localparam int POR_CYCLES      = 16;
  localparam int PULSE_CYCLES    = 8;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int WDT_CYCLES      = 32;
`ifdef RESET_GEN_WDT_EN
  localparam bit WDT_EN = 1'b1;
`else
  localparam bit WDT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic btn      = 1'b0;
  logic sw_req   = 1'b0;
  logic wdt_kick = 1'b1;
  logic       o_rst;
  logic [1:0] o_cause;
  logic       o_done;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  reset_gen dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_btn      (btn),
    .i_sw_req   (sw_req),
`ifdef RESET_GEN_WDT_EN
    .i_wdt_kick (wdt_kick),
`endif
    .o_rst      (o_rst),
    .o_cause    (o_cause),
    .o_done     (o_done),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Countdowns instead of states: por_left/pulse_left are cycles of o_rst still owed,
  // hold means the pulse ended with the button still down, all zero means idle.
  logic        m_valid = 1'b0;
  logic        m_rst   = 1'b1;
  logic        m_done  = 1'b0;
  logic [1:0]  m_cause = 2'b00;
  int          por_left   = 0;
  int          pulse_left = 0;
  int          idle_run   = 0;
  bit          hold       = 1'b0;
  logic [15:0] bhist      = '0;   // bhist[k] = i_btn sampled k+1 edges ago

  always @(posedge clk) begin
    bit pressed;
    int cause;
    if (!rst_n) begin
      m_valid = 1'b1; m_rst = 1'b1; m_done = 1'b0; m_cause = 2'b00;
      por_left = POR_CYCLES; pulse_left = 0; hold = 1'b0; idle_run = 0;
      bhist = '0;
    end else begin
      // Debounced press: the samples that have cleared the two sync stages all high.
      pressed = &bhist[DEBOUNCE_CYCLES+1:2];
      m_done  = 1'b0;
      if (por_left > 0) begin
        por_left--;
        if (por_left == 0) begin m_rst = 1'b0; m_done = 1'b1; idle_run = 0; end
      end else if (pulse_left > 0) begin
        pulse_left--;
        if (pulse_left == 0) begin
          if (pressed) hold = 1'b1;
          else begin m_rst = 1'b0; m_done = 1'b1; idle_run = 0; end
        end
      end else if (hold) begin
        if (!pressed) begin hold = 1'b0; m_rst = 1'b0; m_done = 1'b1; idle_run = 0; end
      end else begin
        cause = -1;
        if (pressed) cause = 1;
        else if (sw_req) cause = 2;
        else if (WDT_EN && !wdt_kick && idle_run == WDT_CYCLES - 1) cause = 3;
        if (cause >= 0) begin
          pulse_left = PULSE_CYCLES; m_rst = 1'b1; m_cause = 2'(cause);
        end else begin
          idle_run = wdt_kick ? 0 : idle_run + 1;
        end
      end
      bhist = {bhist[14:0], btn};
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("o_rst", {7'd0, o_rst}, {7'd0, m_rst});
      check("o_cause", {6'd0, o_cause}, {6'd0, m_cause});
      check("o_done", {7'd0, o_done}, {7'd0, m_done});
    end
  end

  // Event counters; sampled at posedge so they see last cycle's settled outputs.
  int   rise_cnt = 0;
  int   done_cnt = 0;
  logic prev_rst = 1'b1;
  always @(posedge clk) begin
    if (o_rst && !prev_rst) rise_cnt++;
    if (o_done) done_cnt++;
    prev_rst = o_rst;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_high(output int n);
    n = 0;
    while (o_rst === 1'b1 && n < 300) begin n++; @(negedge clk); end
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    while (o_rst !== 1'b1 && n < 300) begin n++; @(negedge clk); end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, r0, d0, btn_left;

    // Power-on: three reset edges, then exactly POR_CYCLES of o_rst.
    rst_n = 1'b0;
    tick(3);
    d0 = done_cnt;
    rst_n = 1'b1;
    count_high(n);
    check("por_width", 8'(n), 8'd16);
    tick(3);
    check("por_done_pulses", 8'(done_cnt - d0), 8'd1);
    check("por_cause", {6'd0, o_cause}, 8'd0);

    // Software request.
    d0 = done_cnt;
    sw_req = 1'b1; tick(1); sw_req = 1'b0;
    count_high(n);
    check("sw_width", 8'(n), 8'd8);
    check("sw_cause", {6'd0, o_cause}, 8'd2);
    check("model_sw_cause", {6'd0, m_cause}, 8'd2);
    tick(3);
    check("sw_done_pulses", 8'(done_cnt - d0), 8'd1);

    // Glitches shorter than the debounce window are ignored.
    r0 = rise_cnt;
    repeat (3) begin btn = 1'b1; tick(1); btn = 1'b0; tick(3); end
    tick(20);
    check("glitch_no_rst", 8'(rise_cnt - r0), 8'd0);

    // Held button: 2 sync edges + 4 debounce edges, o_rst registered one edge later.
    btn = 1'b1;
    wait_rise(n);
    check("btn_latency", 8'(n), 8'd7);
    check("btn_cause", {6'd0, o_cause}, 8'd1);
    tick(20 - 7);
    check("btn_still_held", {7'd0, o_rst}, 8'd1);
    btn = 1'b0;
    count_high(n);
    check("btn_release_tail", 8'(n), 8'd4);
    tick(5);

    // Button and software request on the same edge: button wins, one pulse.
    r0 = rise_cnt;
    btn = 1'b1; tick(6);
    sw_req = 1'b1; tick(1); sw_req = 1'b0; btn = 1'b0;
    check("tie_rst", {7'd0, o_rst}, 8'd1);
    check("tie_cause", {6'd0, o_cause}, 8'd1);
    tick(30);
    check("tie_single_pulse", 8'(rise_cnt - r0), 8'd1);

    // i_rst_n during the third cycle of a pulse restarts the power-on count.
    sw_req = 1'b1; tick(1); sw_req = 1'b0;
    tick(2);
    rst_n = 1'b0; tick(1); rst_n = 1'b1;
    check("midpulse_rst", {7'd0, o_rst}, 8'd1);
    check("midpulse_cause", {6'd0, o_cause}, 8'd0);
    count_high(n);
    check("midpulse_por_width", 8'(n), 8'd16);
    tick(3);

`ifdef RESET_GEN_WDT_EN
    wdt_kick = 1'b0;
    wait_rise(n);
    check("wdt_latency", 8'(n), 8'd32);
    check("wdt_cause", {6'd0, o_cause}, 8'd3);
    wdt_kick = 1'b1;
    count_high(n);
    tick(2);
    r0 = rise_cnt;
    for (int i = 0; i < 200; i++) begin
      wdt_kick = (i % 10 == 0);
      tick(1);
    end
    wdt_kick = 1'b1;
    tick(2);
    check("wdt_kicked_no_rst", 8'(rise_cnt - r0), 8'd0);
`else
    r0 = rise_cnt;
    tick(100);
    check("long_idle_no_rst", 8'(rise_cnt - r0), 8'd0);
`endif

    // Randomized traffic, checked cycle by cycle against the model.
    btn_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (btn_left == 0) begin
        btn = ~btn;
        btn_left = btn ? int'($urandom_range(1, 14)) : int'($urandom_range(1, 30));
      end
      btn_left--;
      sw_req   = ($urandom_range(0, 24) == 0);
      rst_n    = ($urandom_range(0, 399) != 0);
      wdt_kick = ($urandom_range(0, 39) == 0);
      tick(1);
    end
    btn = 1'b0; sw_req = 1'b0; rst_n = 1'b1; wdt_kick = 1'b1;
    tick(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
